// File: rtl/dbg_pc_ctrl.sv
// dbg_pc_ctrl: debug-mode PC controller.
//   Decides when the hart enters debug mode (ebreak, halt request, single
//   step), records the resume PC (dpc) and the cause, and issues fetch
//   redirects through a valid/ready handshake.
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   debug_req_i, step_i          halt request (level), dcsr.step
//   retire_i, ebreak_i           instruction retires / it is an ebreak
//   retire_pc_i, next_pc_i       PC of retiring insn / next PC to execute
//   exc_i, dret_i                exception raised / dret executed
//   redirect_valid_o/_addr_o     fetch redirect request
//   redirect_ready_i             fetch accepts the redirect
//   debug_mode_o, dpc_o, dcause_o  debug status
//
// state        | meaning
// -------------+----------------------------------------------------------
// RUN          | normal execution, watching for debug entry events
// HALT_REDIR   | redirecting fetch to the debug ROM halt entry
// DEBUG        | executing debug ROM code
// EXC_REDIR    | exception inside debug mode, redirect to exception entry
// RESUME_REDIR | dret seen, redirecting fetch back to dpc
module dbg_pc_ctrl #(
  parameter int unsigned DmHaltAddr      = 32'h0000_0800,
  parameter int unsigned DmExceptionAddr = 32'h0000_0808
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        debug_req_i,
  input  logic        step_i,
  input  logic        retire_i,
  input  logic        ebreak_i,
  input  logic [31:0] retire_pc_i,
  input  logic [31:0] next_pc_i,
  input  logic        exc_i,
  input  logic        dret_i,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_addr_o,
  input  logic        redirect_ready_i,
  output logic        debug_mode_o,
  output logic [31:0] dpc_o,
  output logic [2:0]  dcause_o
);

  localparam logic [2:0] StRun         = 3'd0;
  localparam logic [2:0] StHaltRedir   = 3'd1;
  localparam logic [2:0] StDebug       = 3'd2;
  localparam logic [2:0] StExcRedir    = 3'd3;
  localparam logic [2:0] StResumeRedir = 3'd4;

  localparam logic [2:0] CauseEbreak  = 3'd1;
  localparam logic [2:0] CauseHaltReq = 3'd3;
  localparam logic [2:0] CauseStep    = 3'd4;

  localparam logic [31:0] HaltAddr = DmHaltAddr[31:0];
  localparam logic [31:0] ExcAddr  = DmExceptionAddr[31:0];

  logic [2:0]  state;
  logic [2:0]  stateNext;
  logic [31:0] dpcNext;
  logic [2:0]  dcauseNext;
  logic        handshake;

  assign handshake = redirect_valid_o & redirect_ready_i;

  always_comb begin
    stateNext  = state;
    dpcNext    = dpc_o;
    dcauseNext = dcause_o;
    case (state)
      StRun: begin
        if (retire_i && ebreak_i) begin
          stateNext  = StHaltRedir;
          dpcNext    = retire_pc_i;
          dcauseNext = CauseEbreak;
        end else if (debug_req_i) begin
          stateNext  = StHaltRedir;
          dpcNext    = next_pc_i;
          dcauseNext = CauseHaltReq;
        end else if (retire_i && step_i) begin
          stateNext  = StHaltRedir;
          dpcNext    = next_pc_i;
          dcauseNext = CauseStep;
        end
      end
      StHaltRedir: if (handshake) stateNext = StDebug;
      // Re-entry from debug mode keeps dpc/dcause of the original entry.
      StDebug: begin
        if (exc_i)                      stateNext = StExcRedir;
        else if (retire_i && ebreak_i)  stateNext = StHaltRedir;
        else if (dret_i)                stateNext = StResumeRedir;
      end
      StExcRedir:    if (handshake) stateNext = StDebug;
      StResumeRedir: if (handshake) stateNext = StRun;
      default:       stateNext = StRun;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= StRun;
      dpc_o    <= 32'h0;
      dcause_o <= 3'd0;
    end else begin
      state    <= stateNext;
      dpc_o    <= dpcNext;
      dcause_o <= dcauseNext;
    end
  end

  // Redirect outputs decode straight from the state register, so valid and
  // address are held stable for as long as the redirect state persists.
  always_comb begin
    redirect_valid_o = 1'b0;
    redirect_addr_o  = 32'h0;
    case (state)
      StHaltRedir: begin
        redirect_valid_o = 1'b1;
        redirect_addr_o  = HaltAddr;
      end
      StExcRedir: begin
        redirect_valid_o = 1'b1;
        redirect_addr_o  = ExcAddr;
      end
      StResumeRedir: begin
        redirect_valid_o = 1'b1;
        redirect_addr_o  = dpc_o;
      end
      default: ;
    endcase
  end

  assign debug_mode_o = (state != StRun);

endmodule

// File: tb/tb_dbg_pc_ctrl.sv
module tb_dbg_pc_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        debug_req_i = 1'b0;
  logic        step_i = 1'b0;
  logic        retire_i = 1'b0;
  logic        ebreak_i = 1'b0;
  logic [31:0] retire_pc_i = 32'h0;
  logic [31:0] next_pc_i = 32'h0;
  logic        exc_i = 1'b0;
  logic        dret_i = 1'b0;
  logic        redirect_valid_o;
  logic [31:0] redirect_addr_o;
  logic        redirect_ready_i = 1'b1;
  logic        debug_mode_o;
  logic [31:0] dpc_o;
  logic [2:0]  dcause_o;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] dpc;
    logic [2:0]  cause;
  } redirExp_t;

  redirExp_t expQ[$];
  int checks = 0;
  int errors = 0;

  dbg_pc_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .debug_req_i(debug_req_i), .step_i(step_i),
    .retire_i(retire_i), .ebreak_i(ebreak_i), .retire_pc_i(retire_pc_i),
    .next_pc_i(next_pc_i), .exc_i(exc_i), .dret_i(dret_i),
    .redirect_valid_o(redirect_valid_o), .redirect_addr_o(redirect_addr_o),
    .redirect_ready_i(redirect_ready_i), .debug_mode_o(debug_mode_o),
    .dpc_o(dpc_o), .dcause_o(dcause_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on
  // the falling edge, well clear of both.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Scoreboard: every accepted redirect must match the oldest expectation.
  always @(negedge clk_i) begin
    if (!rst_i && redirect_valid_o && redirect_ready_i) begin
      if (expQ.size() == 0) begin
        checkVal("unexpected_redirect", redirect_addr_o, 32'hFFFF_FFFF);
      end else begin
        redirExp_t e;
        e = expQ.pop_front();
        checkVal("redir_addr", redirect_addr_o, e.addr);
        checkVal("redir_dpc", dpc_o, e.dpc);
        checkVal("redir_cause", {29'h0, dcause_o}, {29'h0, e.cause});
        checkVal("redir_dbgmode", {31'h0, debug_mode_o}, 32'h1);
      end
    end
  end

  task automatic expRedir(input logic [31:0] addr, input logic [31:0] dpc, input logic [2:0] cause);
    redirExp_t e;
    e.addr = addr;
    e.dpc = dpc;
    e.cause = cause;
    expQ.push_back(e);
  endtask

  task automatic checkDrained(input string tag);
    checkVal(tag, expQ.size(), 0);
  endtask

  initial begin
    // Reset
    tick(2);
    rst_i = 1'b0;
    checkVal("rst_valid", {31'h0, redirect_valid_o}, 0);
    checkVal("rst_addr", redirect_addr_o, 0);
    checkVal("rst_dbgmode", {31'h0, debug_mode_o}, 0);
    checkVal("rst_dpc", dpc_o, 0);
    checkVal("rst_cause", {29'h0, dcause_o}, 0);

    // Halt request
    next_pc_i = 32'h100; debug_req_i = 1'b1;
    expRedir(32'h800, 32'h100, 3'd3);
    tick();
    debug_req_i = 1'b0;
    checkVal("halt_valid", {31'h0, redirect_valid_o}, 1);
    tick();
    checkDrained("halt_drained");
    checkVal("halt_in_debug_valid", {31'h0, redirect_valid_o}, 0);
    checkVal("halt_in_debug_mode", {31'h0, debug_mode_o}, 1);

    // Debug exception, then resume
    exc_i = 1'b1; expRedir(32'h808, 32'h100, 3'd3);
    tick(); exc_i = 1'b0; tick();
    checkDrained("exc_drained");
    dret_i = 1'b1; expRedir(32'h100, 32'h100, 3'd3);
    tick(); dret_i = 1'b0; tick();
    checkDrained("dret_drained");
    checkVal("resume_dbgmode", {31'h0, debug_mode_o}, 0);

    // Ebreak beats haltreq
    retire_i = 1'b1; ebreak_i = 1'b1; debug_req_i = 1'b1;
    retire_pc_i = 32'h200; next_pc_i = 32'h300;
    expRedir(32'h800, 32'h200, 3'd1);
    tick();
    retire_i = 1'b0; ebreak_i = 1'b0; debug_req_i = 1'b0;
    tick();
    checkDrained("ebreak_drained");

    // Ebreak inside debug with backpressure; other events ignored meanwhile
    redirect_ready_i = 1'b0;
    retire_i = 1'b1; ebreak_i = 1'b1; retire_pc_i = 32'h5A0;
    expRedir(32'h800, 32'h200, 3'd1);
    tick();
    retire_i = 1'b0; ebreak_i = 1'b0;
    exc_i = 1'b1; dret_i = 1'b1; debug_req_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkVal("bp_valid", {31'h0, redirect_valid_o}, 1);
      checkVal("bp_addr", redirect_addr_o, 32'h800);
      tick();
    end
    exc_i = 1'b0; dret_i = 1'b0; debug_req_i = 1'b0;
    redirect_ready_i = 1'b1;
    tick();
    checkDrained("bp_drained");
    checkVal("bp_no_queued_valid", {31'h0, redirect_valid_o}, 0);
    checkVal("bp_dbgmode", {31'h0, debug_mode_o}, 1);

    // Single step: resume, no entry until a retire
    step_i = 1'b1; dret_i = 1'b1;
    expRedir(32'h200, 32'h200, 3'd1);
    tick(); dret_i = 1'b0; tick();
    checkDrained("step_resume_drained");
    tick(3);
    checkVal("step_no_entry", {31'h0, debug_mode_o}, 0);
    retire_i = 1'b1; next_pc_i = 32'h104; retire_pc_i = 32'h100;
    expRedir(32'h800, 32'h104, 3'd4);
    tick();
    retire_i = 1'b0; step_i = 1'b0;
    tick();
    checkDrained("step_drained");

    // RUN ignores exc/dret
    dret_i = 1'b1; expRedir(32'h104, 32'h104, 3'd4);
    tick(); dret_i = 1'b0; tick();
    checkDrained("run_resume_drained");
    exc_i = 1'b1; dret_i = 1'b1;
    tick();
    exc_i = 1'b0; dret_i = 1'b0;
    checkVal("run_ignore_valid", {31'h0, redirect_valid_o}, 0);
    checkVal("run_ignore_dbgmode", {31'h0, debug_mode_o}, 0);

    // Reset mid EXC_REDIR with ready low
    debug_req_i = 1'b1; next_pc_i = 32'h400;
    expRedir(32'h800, 32'h400, 3'd3);
    tick(); debug_req_i = 1'b0; tick();
    checkDrained("pre_rst_drained");
    redirect_ready_i = 1'b0; exc_i = 1'b1;
    tick(); exc_i = 1'b0;
    checkVal("exc_pending_valid", {31'h0, redirect_valid_o}, 1);
    checkVal("exc_pending_addr", redirect_addr_o, 32'h808);
    rst_i = 1'b1; debug_req_i = 1'b1; retire_i = 1'b1; ebreak_i = 1'b1;
    tick();
    rst_i = 1'b0; debug_req_i = 1'b0; retire_i = 1'b0; ebreak_i = 1'b0;
    checkVal("midrst_valid", {31'h0, redirect_valid_o}, 0);
    checkVal("midrst_dbgmode", {31'h0, debug_mode_o}, 0);
    checkVal("midrst_dpc", dpc_o, 0);
    checkVal("midrst_cause", {29'h0, dcause_o}, 0);
    checkVal("midrst_addr", redirect_addr_o, 0);
    redirect_ready_i = 1'b1;
    tick(2);
    checkVal("postrst_valid", {31'h0, redirect_valid_o}, 0);
    checkDrained("final_drained");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
